jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous up/down modulo-N counter whose state register is a bank of JK-style stages.
- Computes the per-bit J/K excitations that drive the next state and exposes them on ports, so the vectors can be cross-checked against a discrete bank of JK flip-flops.
- Sits directly upstream of the JK flip-flop stages in the counter lab designs and is the block that feeds their J/K inputs.
- Provides synchronous preset, parallel load, count enable, direction control and terminal-count flags.

Parameters:
- WIDTH, 4, number of counter bits (JK stages).
- MODULUS, 10, count sequence length. Legal range is 2 <= MODULUS <= 2**WIDTH; outside this range the design is illegal and fails elaboration.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-high reset; forces Q=0 immediately.
- pr  input  1  synchronous preset; loads MODULUS-1.
- load  input  1  synchronous parallel load of din.
- din  input  WIDTH  load value.
- en  input  1  count enable.
- up  input  1  direction: 1 = up, 0 = down.
- Q  output  WIDTH  current count (registered).
- _Q  output  WIDTH  bitwise complement of Q.
- J  output  WIDTH  per-bit J excitation for the next edge (combinational).
- K  output  WIDTH  per-bit K excitation for the next edge (combinational).
- tc  output  1  terminal count (combinational).
- err  output  1  one-cycle registered pulse flagging an out-of-range load.

Behaviour:
- Reset: clr=1 at any time, independent of clk, forces Q=0, _Q=all ones and err=0. This also applies mid-count or mid-load. The first rising edge after clr deasserts evaluates normally.
- Priority at each rising edge, highest first: pr > load > en > hold.
- Next-state N:
  - pr: N = MODULUS-1.
  - load with din < MODULUS: N = din.
  - load with din >= MODULUS: N = 0, and err = 1 for the following cycle.
  - en & up: N = (Q == MODULUS-1) ? 0 : Q+1.
  - en & ~up: N = (Q == 0) ? MODULUS-1 : Q-1.
  - otherwise: N = Q.
- Excitations, per bit i:
  - J[i] = ~Q[i] & N[i]
  - K[i] = Q[i] & ~N[i]
  - Consequences: J and K are never both 1 (no toggle encoding used), and both are 0 on hold.
- Register update is Q <= (Q & ~K) | (~Q & J). This is identical to Q <= N; the implementation uses the JK form.
- Latency: Q reflects a command one clock after the edge that samples it. J and K reflect the current inputs and Q within the same cycle.
- tc = en & ~pr & ~load & ((up & Q == MODULUS-1) | (~up & Q == 0)). tc is asserted in the cycle before the wrap edge.
- err is registered: it is set by an out-of-range load and cleared on the next edge unless another out-of-range load occurs. pr has priority, so an out-of-range din with pr=1 and load=1 raises no err.
- Out-of-range states cannot be reached, since load is guarded and the arithmetic is wrapped.
- Direction change mid-sequence takes effect on the next edge, with no dead cycle.
- MODULUS = 2**WIDTH gives plain binary wrap; the compare logic still applies.
- _Q always equals ~Q, including during clr.

Test Plan:
- Reset and hold: assert clr mid-cycle while Q=7 -> Q=0 and _Q=4'hF before the next edge. Release clr with en=0 for 3 clocks -> Q stays 0 and J=K=0.
- Up-count wrap (WIDTH=4, MODULUS=10): en=1, up=1 for 12 clocks from 0 -> Q runs 1..9,0,1,2. tc=1 only while Q=9. At Q=9: J=4'b0000, K=4'b1001.
- Down-count wrap: en=1, up=0 from Q=1 -> Q=0 then 9. tc=1 while Q=0. At Q=0: J=4'b1001, K=0.
- Load and range check: load=1, din=6 -> Q=6, err=0. load=1, din=12 -> Q=0, err=1 for exactly one cycle. pr=1, load=1, din=12 -> Q=9, err=0.
- Priority: pr=1, load=1, din=3, en=1 on the same edge -> Q=9. load=1, din=3, en=1 -> Q=3, no increment.
- Direction flip and excitation check: count up to 5, set up=0 -> Q=4. Compare J/K against a reference JK bank every cycle over 40 random cycles -> zero mismatches, and J&K never set on any bit.

Source files
------------

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from JK-style stages; J/K excitations exported for cross-checking.
// Latency: Q updates one clk after a command is sampled; J, K and tc are combinational from inputs and Q.
// Backpressure: none, since every edge is accepted and clr clears asynchronously.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] _Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             tc,
    output logic             err
);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
    // Widened by one bit so MODULUS == 2**WIDTH is still representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic             err_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAXV);
    assign at_zero = (q == '0);

    always_comb begin
        nxt     = q;
        err_nxt = 1'b0;
        if (pr) begin
            nxt = MAXV;
        end else if (load) begin
            if ({1'b0, din} < MOD_EXT) begin
                nxt = din;
            end else begin
                nxt     = '0;
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                nxt = at_max ? '0 : q + WIDTH'(1);
            end else begin
                nxt = at_zero ? MAXV : q - WIDTH'(1);
            end
        end
    end

    // Set only bits that must rise, reset only bits that must fall; toggle is never used.
    assign J  = ~q & nxt;
    assign K  = q & ~nxt;
    assign tc = en & ~pr & ~load & ((up & at_max) | (~up & at_zero));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q   <= '0;
            err <= 1'b0;
        end else begin
            q   <= (q & ~K) | (~q & J);
            err <= err_nxt;
        end
    end

    assign Q  = q;
    assign _Q = ~q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: expected next state queued at drive time, checked after the edge.
module tb_jk_mod_counter;
    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         clr, pr, load, en, up;
    logic [W-1:0] din;
    logic [W-1:0] Q, qb, J, K;
    logic         tc, err;

    jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .clr(clr), .pr(pr), .load(load), .din(din), .en(en), .up(up),
        .Q(Q), ._Q(qb), .J(J), .K(K), .tc(tc), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mq;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clocked command: check combinational outputs, queue the expected next state, compare after the edge.
    task automatic step(input logic p, input logic l, input logic [W-1:0] d,
                        input logic e, input logic u);
        int           ni;
        logic [W-1:0] n, ej, ek, eqb;
        logic         eerr, etc;
        exp_t         x;
        @(negedge clk);
        pr = p; load = l; din = d; en = e; up = u;
        eerr = 1'b0;
        if (p)                ni = M - 1;
        else if (l) begin
            if (int'(d) < M)  ni = int'(d);
            else begin        ni = 0; eerr = 1'b1; end
        end
        else if (e && u)      ni = (int'(mq) == M - 1) ? 0 : int'(mq) + 1;
        else if (e)           ni = (mq == 0) ? M - 1 : int'(mq) - 1;
        else                  ni = int'(mq);
        n   = W'(ni);
        ej  = ~mq & n;
        ek  = mq & ~n;
        etc = e & ~p & ~l & ((u & (int'(mq) == M - 1)) | (~u & (mq == 0)));
        #1;
        check("J", J, ej);
        check("K", K, ek);
        check("J_and_K", J & K, 0);
        check("tc", tc, etc);
        sb.push_back('{q: n, err: eerr});
        @(posedge clk);
        #1;
        x   = sb.pop_front();
        eqb = ~x.q;
        check("Q", Q, x.q);
        check("_Q", qb, eqb);
        check("err", err, x.err);
        mq = x.q;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ones;
        ones = '1;
        clr = 1'b1; pr = 1'b0; load = 1'b0; din = '0; en = 1'b0; up = 1'b1;
        mq = '0;
        #1;
        check("reset_Q", Q, 0);
        check("reset__Q", qb, ones);
        check("reset_err", err, 0);
        @(negedge clk);
        clr = 1'b0;

        // Asynchronous clear mid-cycle from Q=7.
        step(0, 1, 4'd7, 0, 1);
        #2;
        pr = 1'b0; load = 1'b0; en = 1'b0;
        clr = 1'b1;
        #1;
        check("clr_Q", Q, 0);
        check("clr__Q", qb, ones);
        check("clr_err", err, 0);
        @(negedge clk);
        clr = 1'b0;
        mq  = '0;

        // Hold with en=0: Q stays 0, J=K=0.
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 0, 1);

        // Up-count wrap: 1..9,0,1,2.
        for (int i = 0; i < 12; i++) step(0, 0, 4'd0, 1, 1);

        // Down-count wrap from 1: 0 then 9.
        step(0, 1, 4'd1, 0, 0);
        step(0, 0, 4'd0, 1, 0);
        step(0, 0, 4'd0, 1, 0);

        // Load and range check; err lasts exactly one cycle.
        step(0, 1, 4'd6, 0, 1);
        step(0, 1, 4'd12, 0, 1);
        step(0, 0, 4'd0, 0, 1);
        step(1, 1, 4'd12, 0, 1);

        // Priority.
        step(0, 1, 4'd0, 0, 1);
        step(1, 1, 4'd3, 1, 1);
        step(0, 1, 4'd3, 1, 1);

        // Direction flip: up to 5, then down to 4.
        step(0, 1, 4'd3, 0, 1);
        step(0, 0, 4'd0, 1, 1);
        step(0, 0, 4'd0, 1, 1);
        step(0, 0, 4'd0, 1, 0);

        // Random cycles against the reference model.
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 W'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
